// File: rtl/riscv141_pkg.sv
// riscv141_pkg: shared pipeline states, control bundle and register constants for the Riscv141 sequencer
package riscv141_pkg;
  typedef enum logic [2:0] {INIT, RUN, REDIR, BUBBLE, WAIT} state_t;
  typedef struct packed {
    logic pc_en;
    logic id_ex_en;
    logic ex_wb_en;
    logic id_ex_flush;
  } ctrl_t;
  localparam logic [4:0] X0 = 5'd0;
  localparam logic [1:0] NOP_FWD = 2'b00;
  function automatic ctrl_t ctrl_of(state_t s);
    return s == INIT || s == BUBBLE ? ctrl_t'(4'b0111) :
           s == REDIR               ? ctrl_t'(4'b1111) :
           s == WAIT                ? ctrl_t'(4'b0000) : ctrl_t'(4'b1110);
  endfunction
endpackage

// File: rtl/riscv_fwd_cmp.sv
// riscv_fwd_cmp: ID-source vs EX-destination comparator producing forward selects and load-use hazard
module riscv_fwd_cmp
  import riscv141_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_we,
  input  logic       ex_is_load,
  output logic       fwd_a_next,
  output logic       fwd_b_next,
  output logic       load_use
);
  assign fwd_a_next = ex_we && ex_rd != X0 && id_use_rs1 && id_rs1 == ex_rd;
  assign fwd_b_next = ex_we && ex_rd != X0 && id_use_rs2 && id_rs2 == ex_rd;
  assign load_use = ex_is_load && (fwd_a_next || fwd_b_next);
endmodule

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl: Riscv141 stage enables, squashes, forward selects and lost-cycle counter; HAZARD_LOAD_BYPASS_EN removes the load-use bubble
module riscv_hazard_ctrl
  import riscv141_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             id_ex_en,
  output logic             ex_wb_en,
  output logic             id_ex_flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [CNT_W-1:0] lost_cycles
);
`ifdef HAZARD_LOAD_BYPASS_EN
  localparam logic BUBBLE_EN = 1'b0;
`else
  localparam logic BUBBLE_EN = 1'b1;
`endif
  state_t state, saved, eff, next;
  ctrl_t ctrl;
  logic fa_next, fb_next, load_use, bubble;
  riscv_fwd_cmp u_cmp (
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd),
    .ex_we(ex_we),
    .ex_is_load(ex_is_load),
    .fwd_a_next(fa_next),
    .fwd_b_next(fb_next),
    .load_use(load_use)
  );
  assign eff = state == WAIT ? saved : state;
  assign bubble = BUBBLE_EN && load_use;
  // the RUN cycle that sees the hazard is itself the bubble, so the load reaches WB before the held instruction re-decodes
  always_comb begin
    ctrl = stall ? ctrl_of(WAIT) : eff != RUN ? ctrl_of(eff) :
           ex_redirect ? ctrl_of(REDIR) : bubble ? ctrl_of(BUBBLE) : ctrl_of(RUN);
    next = stall ? WAIT : eff == RUN && ex_redirect ? REDIR : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      saved <= INIT;
      {fwd_a, fwd_b} <= NOP_FWD;
      lost_cycles <= '0;
    end else begin
      state <= next;
      if (stall && state != WAIT) saved <= state;
      if (ctrl.id_ex_en) {fwd_a, fwd_b} <= ctrl.id_ex_flush ? NOP_FWD : {fa_next, fb_next};
      if (!ctrl.pc_en || ctrl.id_ex_flush) lost_cycles <= lost_cycles + CNT_W'(1);
    end
  end
  assign pc_en = ctrl.pc_en;
  assign id_ex_en = ctrl.id_ex_en;
  assign ex_wb_en = ctrl.ex_wb_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  redirect_only_in_run: assert property (@(posedge clk) disable iff (reset) !(ex_redirect && !stall && eff != RUN));
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb_riscv_hazard_ctrl: directed vectors checked every cycle against a rule-level model plus literal expectations
module tb_riscv_hazard_ctrl;
  localparam int CW = 4;
`ifdef HAZARD_LOAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, reset = 1, stall = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_we = 0, ex_is_load = 0, ex_redirect = 0;
  logic pc_en, id_ex_en, ex_wb_en, id_ex_flush, fwd_a, fwd_b;
  logic [CW-1:0] lost_cycles;
  int total = 0, bad = 0;
  bit m_init, m_redir, m_fa, m_fb, ha, hb, lu;
  int m_lost;
  logic [3:0] e;
  always #5 clk = ~clk;
  riscv_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .pc_en(pc_en), .id_ex_en(id_ex_en), .ex_wb_en(ex_wb_en), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .lost_cycles(lost_cycles)
  );
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, act, exp, $time);
    end
  endfunction
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_we, ex_is_load, ex_redirect} = '0;
  endtask
  // model: pending squash flags for init/redirect, expected EX forward bits, lost-cycle tally
  always @(negedge clk) begin
    if (reset) begin
      m_init = 1; m_redir = 0; m_fa = 0; m_fb = 0; m_lost = 0;
    end else begin
      ha = ex_we && ex_rd != 0 && id_use_rs1 && id_rs1 == ex_rd;
      hb = ex_we && ex_rd != 0 && id_use_rs2 && id_rs2 == ex_rd;
      lu = !BYP && ex_is_load && (ha || hb);
      e = stall ? 4'b0000 : m_init ? 4'b0111 : (m_redir || ex_redirect) ? 4'b1111 : lu ? 4'b0111 : 4'b1110;
      chk("pc_en", pc_en, e[3]);
      chk("id_ex_en", id_ex_en, e[2]);
      chk("ex_wb_en", ex_wb_en, e[1]);
      chk("id_ex_flush", id_ex_flush, e[0]);
      chk("fwd_a", fwd_a, m_fa);
      chk("fwd_b", fwd_b, m_fb);
      chk("lost_cycles", lost_cycles, m_lost);
      if (!stall) begin
        m_fa = e[0] ? 1'b0 : ha;
        m_fb = e[0] ? 1'b0 : hb;
        m_redir = !m_init && !m_redir && ex_redirect;
        m_init = 0;
      end
      if (!e[3] || e[0]) m_lost = (m_lost + 1) % (1 << CW);
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk); chk("init_pc", pc_en, 0); chk("init_flush", id_ex_flush, 1); chk("init_ie", id_ex_en, 1); chk("init_lost", lost_cycles, 0);
    nx(); @(negedge clk); chk("run_pc", pc_en, 1); chk("run_flush", id_ex_flush, 0); chk("run_lost", lost_cycles, 1);
    nx(); ex_redirect = 1;
    @(negedge clk); chk("redir1_flush", id_ex_flush, 1); chk("redir1_pc", pc_en, 1);
    nx(); ex_redirect = 0;
    @(negedge clk); chk("redir2_flush", id_ex_flush, 1); chk("redir2_pc", pc_en, 1); chk("redir2_lost", lost_cycles, 2);
    nx(); @(negedge clk); chk("redir_done", id_ex_flush, 0); chk("redir_lost", lost_cycles, 3);
    nx(); ex_rd = 5; ex_we = 1; ex_is_load = 1; id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk); chk("lu_pc", pc_en, BYP); chk("lu_flush", id_ex_flush, !BYP);
    nx(); ex_rd = 0; ex_we = 0; ex_is_load = 0;
    @(negedge clk); chk("lu_fwd_a", fwd_a, BYP); chk("lu_lost", lost_cycles, BYP ? 3 : 4); chk("lu_resume", pc_en, 1);
    nx(); ex_we = 1; ex_is_load = 1; id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk); chk("x0_pc", pc_en, 1); chk("x0_flush", id_ex_flush, 0);
    nx(); clear();
    @(negedge clk); chk("x0_fwd_a", fwd_a, 0);
    nx(); ex_rd = 7; ex_we = 1; id_rs2 = 7; id_use_rs2 = 1; id_rs1 = 3; id_use_rs1 = 1;
    nx(); clear();
    @(negedge clk); chk("alu_fwd_b", fwd_b, 1); chk("alu_fwd_a", fwd_a, 0);
    nx(); ex_rd = 7; ex_we = 1; ex_is_load = 1; id_rs2 = 7;
    @(negedge clk); chk("unused_src_pc", pc_en, 1);
    nx(); clear();
    @(negedge clk); chk("unused_src_fwd_b", fwd_b, 0);
    nx(); ex_redirect = 1;
    nx(); ex_redirect = 0; stall = 1;
    @(negedge clk); chk("stall_pc", pc_en, 0); chk("stall_ie", id_ex_en, 0); chk("stall_ew", ex_wb_en, 0); chk("stall_flush", id_ex_flush, 0);
    repeat (3) begin nx(); @(negedge clk); chk("stall_hold", {pc_en, id_ex_en, ex_wb_en, id_ex_flush}, 0); end
    nx(); stall = 0;
    @(negedge clk); chk("resume_redir_flush", id_ex_flush, 1); chk("resume_redir_pc", pc_en, 1);
    nx(); @(negedge clk); chk("resume_run", id_ex_flush, 0);
    nx(); stall = 1; ex_redirect = 1;
    @(negedge clk); chk("stall_redir_pc", pc_en, 0); chk("stall_redir_flush", id_ex_flush, 0);
    nx(); stall = 0;
    @(negedge clk); chk("late_redir_flush", id_ex_flush, 1);
    nx(); ex_redirect = 0;
    @(negedge clk); chk("late_redir2_flush", id_ex_flush, 1);
    nx(); ex_redirect = 1;
    nx(); ex_redirect = 0; reset = 1;
    nx(); reset = 0;
    @(negedge clk); chk("rst_redir_pc", pc_en, 0); chk("rst_redir_flush", id_ex_flush, 1); chk("rst_redir_lost", lost_cycles, 0);
    nx(); stall = 1;
    nx(); reset = 1;
    nx(); reset = 0; stall = 0;
    @(negedge clk); chk("rst_wait_pc", pc_en, 0); chk("rst_wait_flush", id_ex_flush, 1); chk("rst_wait_lost", lost_cycles, 0);
    nx(); stall = 1;
    repeat (13) nx();
    nx(); stall = 0; ex_rd = 9; ex_we = 1; ex_is_load = 1; id_rs2 = 9; id_use_rs2 = 1;
    @(negedge clk); chk("pre_wrap_lost", lost_cycles, 15);
    nx(); clear();
    @(negedge clk); chk("wrap_lost", lost_cycles, BYP ? 15 : 0);
    nx(); @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
